tlb_walk_arbiter: RTL and testbench
===================================

TLB_WALK_ARBITER -- requirements
Module: tlb_walk_arbiter

Interface
REQ-001: Parameter ADDR_WIDTH, default 64, width of walk addresses.
REQ-002: Parameter DATA_WIDTH, default 64, width of PTE data.
REQ-003: Parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before an access error.
REQ-004: CLK  input  1  clock; RST  input  1  reset, synchronous, active-high.
REQ-005: I_REQ_VALID  input  1  ITLB walk request; I_REQ_ADDR  input  ADDR_WIDTH  ITLB PTE address.
REQ-006: I_REQ_READY  output  1  ITLB request accepted this cycle.
REQ-007: I_RESP_VALID  output  1  ITLB response strobe; I_RESP_DATA  output  DATA_WIDTH  PTE; I_RESP_ERR  output  1  access error (timeout).
REQ-008: D_REQ_VALID, D_REQ_ADDR, D_REQ_READY, D_RESP_VALID, D_RESP_DATA, D_RESP_ERR: DTLB equivalents of REQ-005..007, same directions and widths.
REQ-009: M_ADDR_VALID  output  1; M_ADDR  output  ADDR_WIDTH; M_ADDR_READY  input  1  address accepted by the AXI master.
REQ-010: M_DATA_VALID  input  1; M_DATA  input  DATA_WIDTH  read data from the AXI master.

Function
REQ-011: The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP, with exactly one transaction outstanding at any time.
REQ-012: In IDLE with any REQ_VALID high, the FSM SHALL grant one requester, pulse its REQ_READY combinationally in that cycle, latch the address and owner, and enter ISSUE.
REQ-013: If both requesters are valid in the same IDLE cycle, the grant SHALL go to the requester not granted last (round-robin).
REQ-014: When only one requester is valid, it SHALL be granted regardless of round-robin history.
REQ-015: REQ_READY SHALL be 0 in every state except IDLE.
REQ-016: In ISSUE, M_ADDR_VALID SHALL be 1 and M_ADDR SHALL equal the latched address, held stable until M_ADDR_READY.
REQ-017: In ISSUE, when M_ADDR_READY is 1, the FSM SHALL enter WAIT on the next cycle.
REQ-018: In WAIT, the timeout counter SHALL increment every cycle; it SHALL clear on entry to WAIT.
REQ-019: In WAIT, M_DATA_VALID SHALL latch M_DATA and move the FSM to RESP with the error flag at 0.
REQ-020: In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with no data, the FSM SHALL move to RESP with the error flag at 1 and data at 0.
REQ-021: If data arrives in the same cycle the timeout expires, data SHALL win and ERR SHALL be 0.
REQ-022: In RESP, the owner's RESP_VALID SHALL be 1 for exactly one cycle with the latched data and ERR; the other requester's RESP_VALID SHALL stay 0.
REQ-023: From RESP, the FSM SHALL return to IDLE, where a new grant is possible in the following cycle.
REQ-024: M_DATA_VALID outside WAIT SHALL be ignored: no state change and no response.
REQ-025: Latency SHALL be: grant at cycle N, M_ADDR_VALID at N+1, RESP_VALID one cycle after data is accepted.
REQ-026: A requester dropping REQ_VALID after grant SHALL NOT abort the transaction.

Reset
REQ-027: On RST, the FSM SHALL enter IDLE, and the counter, latched address, data and error flag SHALL clear.
REQ-028: On RST, all outputs SHALL be 0.
REQ-029: On RST, round-robin history SHALL be set so that the ITLB wins the first simultaneous request.
REQ-030: RST asserted mid-transaction SHALL abandon it with no response; late M_DATA_VALID after reset SHALL be ignored (REQ-024).

Verification
REQ-031: After reset, both REQ_VALID high, addresses 0x1000 (I) and 0x2000 (D) -> I_REQ_READY pulses, then M_ADDR=0x1000; after the response, D is granted and M_ADDR=0x2000.
REQ-032: Only D requesting (addr 0x3008), M_ADDR_READY held low for 3 cycles -> M_ADDR_VALID stays high for 4 cycles with M_ADDR stable at 0x3008.
REQ-033: I request, M_DATA=0x0000_0000_2000_00CF after 5 WAIT cycles -> I_RESP_VALID for one cycle with that data and I_RESP_ERR=0; D_RESP_VALID stays 0.
REQ-034: TIMEOUT_CYCLES=8, no M_DATA_VALID -> RESP_VALID with ERR=1 and DATA=0 after 8 WAIT cycles; repeat with data on cycle 8 -> ERR=0.
REQ-035: RST pulsed while in WAIT, then M_DATA_VALID -> no RESP_VALID, FSM in IDLE, all outputs 0.
REQ-036: M_DATA_VALID pulsed while in IDLE and ISSUE -> no response and no state change.

Source files
------------

// File: rtl/tlb_walk_arbiter_if.sv
// Bus bundle between the ITLB/DTLB walkers, the walk arbiter and the AXI read master.
// The arbiter connects through the master modport; the environment uses the slave modport.
interface tlb_walk_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  I_REQ_VALID;
  logic [ADDR_WIDTH-1:0] I_REQ_ADDR;
  logic                  I_REQ_READY;
  logic                  I_RESP_VALID;
  logic [DATA_WIDTH-1:0] I_RESP_DATA;
  logic                  I_RESP_ERR;

  logic                  D_REQ_VALID;
  logic [ADDR_WIDTH-1:0] D_REQ_ADDR;
  logic                  D_REQ_READY;
  logic                  D_RESP_VALID;
  logic [DATA_WIDTH-1:0] D_RESP_DATA;
  logic                  D_RESP_ERR;

  logic                  M_ADDR_VALID;
  logic [ADDR_WIDTH-1:0] M_ADDR;
  logic                  M_ADDR_READY;
  logic                  M_DATA_VALID;
  logic [DATA_WIDTH-1:0] M_DATA;

  modport master (
    input  I_REQ_VALID, I_REQ_ADDR, D_REQ_VALID, D_REQ_ADDR,
    input  M_ADDR_READY, M_DATA_VALID, M_DATA,
    output I_REQ_READY, I_RESP_VALID, I_RESP_DATA, I_RESP_ERR,
    output D_REQ_READY, D_RESP_VALID, D_RESP_DATA, D_RESP_ERR,
    output M_ADDR_VALID, M_ADDR
  );

  modport slave (
    output I_REQ_VALID, I_REQ_ADDR, D_REQ_VALID, D_REQ_ADDR,
    output M_ADDR_READY, M_DATA_VALID, M_DATA,
    input  I_REQ_READY, I_RESP_VALID, I_RESP_DATA, I_RESP_ERR,
    input  D_REQ_READY, D_RESP_VALID, D_RESP_DATA, D_RESP_ERR,
    input  M_ADDR_VALID, M_ADDR
  );
endinterface

// File: rtl/tlb_walk_arbiter.sv
// Round-robin arbiter sharing one AXI read master between ITLB and DTLB page walks,
// one outstanding PTE read at a time, with a WAIT-phase timeout reported as an access error.
module tlb_walk_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  tlb_walk_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic grant_i, grant_d, data_take, timeout, resp_active;

  // Grant only from IDLE; on a tie the side that did not win last time goes first.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE && !RST) begin
      if (bus.I_REQ_VALID && bus.D_REQ_VALID) begin
        grant_i = (last_q == OWN_D);
        grant_d = (last_q == OWN_I);
      end else begin
        grant_i = bus.I_REQ_VALID;
        grant_d = bus.D_REQ_VALID;
      end
    end
  end

  assign data_take = (state_q == WAIT) && bus.M_DATA_VALID;
  assign timeout   = (state_q == WAIT) && !bus.M_DATA_VALID &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_i || grant_d)     state_d = ISSUE;
      ISSUE:   if (bus.M_ADDR_READY)       state_d = WAIT;
      WAIT:    if (data_take || timeout)   state_d = RESP;
      RESP:                                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i || grant_d) begin
        owner_q <= grant_d ? OWN_D : OWN_I;
        last_q  <= grant_d ? OWN_D : OWN_I;
        addr_q  <= grant_d ? bus.D_REQ_ADDR : bus.I_REQ_ADDR;
      end
      // Held at zero outside WAIT, so it always starts from zero on entry.
      cnt_q <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
      if (data_take) begin
        data_q <= bus.M_DATA;
        err_q  <= 1'b0;
      end else if (timeout) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  // Outputs are forced quiet while RST is high, even before the first reset edge.
  assign resp_active      = !RST && (state_q == RESP);
  assign bus.I_REQ_READY  = grant_i;
  assign bus.D_REQ_READY  = grant_d;
  assign bus.M_ADDR_VALID = !RST && (state_q == ISSUE);
  assign bus.M_ADDR       = bus.M_ADDR_VALID ? addr_q : '0;

  assign bus.I_RESP_VALID = resp_active && (owner_q == OWN_I);
  assign bus.I_RESP_DATA  = bus.I_RESP_VALID ? data_q : '0;
  assign bus.I_RESP_ERR   = bus.I_RESP_VALID && err_q;
  assign bus.D_RESP_VALID = resp_active && (owner_q == OWN_D);
  assign bus.D_RESP_DATA  = bus.D_RESP_VALID ? data_q : '0;
  assign bus.D_RESP_ERR   = bus.D_RESP_VALID && err_q;

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Bench for tlb_walk_arbiter: directed and random walk transactions checked against
// a transaction-level model (round-robin owner, latency arithmetic, timeout rule).
module tb_tlb_walk_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  tlb_walk_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tlb_walk_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int last_owner;  // 0 = ITLB won last, 1 = DTLB won last

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.I_REQ_VALID  = 1'b0;
    bus.D_REQ_VALID  = 1'b0;
    bus.I_REQ_ADDR   = '0;
    bus.D_REQ_ADDR   = '0;
    bus.M_ADDR_READY = 1'b0;
    bus.M_DATA_VALID = 1'b0;
    bus.M_DATA       = '0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.I_REQ_READY, bus.D_REQ_READY, bus.M_ADDR_VALID,
                              bus.I_RESP_VALID, bus.D_RESP_VALID, bus.I_RESP_ERR, bus.D_RESP_ERR}), 64'd0);
    check({tag, "_maddr"}, bus.M_ADDR, 64'd0);
    check({tag, "_rdata"}, bus.I_RESP_DATA | bus.D_RESP_DATA, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    bus.I_REQ_VALID = 1'b1;  // ready must stay low while in reset
    #1 all_zero("rst_hold");
    @(negedge CLK);
    bus.I_REQ_VALID = 1'b0;
    #1 all_zero("rst_done");
    RST = 1'b0;
    last_owner = 1;
  endtask

  // One full walk starting from IDLE. adly = cycles M_ADDR_READY is held low in ISSUE,
  // ddly = WAIT cycle (1-based) on which data arrives; ddly > TO means it never does.
  task automatic run_txn(input bit iv, input bit dv, input logic [63:0] ia, input logic [63:0] da,
                         input int adly, input int ddly, input logic [63:0] data);
    int owner;
    int nwait;
    bit err;
    logic [63:0] exp_addr;

    @(negedge CLK);
    bus.I_REQ_VALID  = iv;
    bus.D_REQ_VALID  = dv;
    bus.I_REQ_ADDR   = ia;
    bus.D_REQ_ADDR   = da;
    bus.M_ADDR_READY = 1'b0;
    bus.M_DATA_VALID = 1'($urandom % 2);  // stray data in IDLE must be ignored
    bus.M_DATA       = rnd64();
    owner    = (iv && dv) ? (1 - last_owner) : (iv ? 0 : 1);
    exp_addr = (owner == 1) ? da : ia;
    #1;
    check("grant_i", 64'(bus.I_REQ_READY), 64'(owner == 0));
    check("grant_d", 64'(bus.D_REQ_READY), 64'(owner == 1));
    check("idle_resp", 64'({bus.I_RESP_VALID, bus.D_RESP_VALID}), 64'd0);
    last_owner = owner;

    for (int k = 0; k <= adly; k++) begin
      @(negedge CLK);
      bus.I_REQ_VALID  = iv & 1'($urandom % 2);  // dropping the request must not abort
      bus.D_REQ_VALID  = dv & 1'($urandom % 2);
      bus.M_ADDR_READY = (k == adly);
      bus.M_DATA_VALID = 1'($urandom % 2);       // stray data in ISSUE must be ignored
      bus.M_DATA       = rnd64();
      #1;
      check("issue_valid", 64'(bus.M_ADDR_VALID), 64'd1);
      check("issue_addr", bus.M_ADDR, exp_addr);
      check("issue_ready", 64'({bus.I_REQ_READY, bus.D_REQ_READY}), 64'd0);
      check("issue_resp", 64'({bus.I_RESP_VALID, bus.D_RESP_VALID}), 64'd0);
    end

    err   = (ddly > TO);
    nwait = err ? TO : ddly;
    for (int w = 1; w <= nwait; w++) begin
      @(negedge CLK);
      bus.M_ADDR_READY = 1'b0;
      bus.M_DATA_VALID = (w == ddly);
      bus.M_DATA       = (w == ddly) ? data : rnd64();
      #1;
      check("wait_addrv", 64'(bus.M_ADDR_VALID), 64'd0);
      check("wait_resp", 64'({bus.I_RESP_VALID, bus.D_RESP_VALID}), 64'd0);
      check("wait_ready", 64'({bus.I_REQ_READY, bus.D_REQ_READY}), 64'd0);
    end

    @(negedge CLK);
    bus.M_DATA_VALID = 1'($urandom % 2);
    bus.M_DATA       = rnd64();
    #1;
    check("resp_i_valid", 64'(bus.I_RESP_VALID), 64'(owner == 0));
    check("resp_d_valid", 64'(bus.D_RESP_VALID), 64'(owner == 1));
    check("resp_data", (owner == 1) ? bus.D_RESP_DATA : bus.I_RESP_DATA, err ? 64'd0 : data);
    check("resp_err", 64'((owner == 1) ? bus.D_RESP_ERR : bus.I_RESP_ERR), 64'(err));
    check("resp_ready", 64'({bus.I_REQ_READY, bus.D_REQ_READY}), 64'd0);
  endtask

  task automatic idle_stray(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      idle_inputs();
      bus.M_DATA_VALID = 1'b1;
      bus.M_DATA       = rnd64();
      #1 check("idle_stray", 64'({bus.M_ADDR_VALID, bus.I_RESP_VALID, bus.D_RESP_VALID,
                                  bus.I_REQ_READY, bus.D_REQ_READY}), 64'd0);
    end
  endtask

  task automatic reset_mid_wait();
    @(negedge CLK);
    idle_inputs();
    bus.I_REQ_VALID = 1'b1;
    bus.I_REQ_ADDR  = 64'h5000;
    @(negedge CLK);
    bus.I_REQ_VALID  = 1'b0;
    bus.M_ADDR_READY = 1'b1;
    #1 check("rmw_issue", 64'(bus.M_ADDR_VALID), 64'd1);
    @(negedge CLK);
    bus.M_ADDR_READY = 1'b0;
    @(negedge CLK);
    #1 check("rmw_wait", 64'({bus.M_ADDR_VALID, bus.I_RESP_VALID}), 64'd0);
    RST = 1'b1;
    #1 all_zero("rmw_rst");
    @(negedge CLK);
    RST = 1'b0;
    last_owner = 1;
    bus.M_DATA_VALID = 1'b1;
    bus.M_DATA       = 64'hDEAD_BEEF_0000_0001;
    #1 all_zero("rmw_late1");
    @(negedge CLK);
    #1 all_zero("rmw_late2");
    @(negedge CLK);
    bus.M_DATA_VALID = 1'b0;
    #1 all_zero("rmw_late3");
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    last_owner = 1;
    repeat (2) @(negedge CLK);
    reset_dut();

    // Tie after reset: ITLB first, then DTLB.
    run_txn(1'b1, 1'b1, 64'h1000, 64'h2000, 0, 2, rnd64());
    run_txn(1'b1, 1'b1, 64'h1000, 64'h2000, 0, 2, rnd64());
    // DTLB alone, address stall of 3 cycles.
    run_txn(1'b0, 1'b1, 64'h0, 64'h3008, 3, 3, rnd64());
    // ITLB alone, data on 5th WAIT cycle.
    run_txn(1'b1, 1'b0, 64'h4000, 64'h0, 0, 5, 64'h0000_0000_2000_00CF);
    // Timeout, then data exactly on the timeout cycle.
    run_txn(1'b1, 1'b0, 64'h4010, 64'h0, 1, TO + 1, rnd64());
    run_txn(1'b0, 1'b1, 64'h0, 64'h4020, 0, TO, 64'h1234_5678_9ABC_DEF0);
    run_txn(1'b1, 1'b0, 64'h4030, 64'h0, 0, 1, rnd64());

    idle_stray(3);
    reset_mid_wait();
    run_txn(1'b1, 1'b1, 64'h6000, 64'h7000, 0, 1, rnd64());

    for (int n = 0; n < 40; n++) begin
      bit iv, dv;
      iv = 1'($urandom % 2);
      dv = 1'($urandom % 2);
      if (!iv && !dv) idle_stray(1);
      else run_txn(iv, dv, rnd64(), rnd64(), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, TO + 2)), rnd64());
    end

    reset_dut();
    run_txn(1'b1, 1'b1, 64'h8000, 64'h9000, 0, 2, rnd64());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
